acc_pipe: RTL
=============

// Module: acc_pipe
// PURPOSE
//   Parametrised, segment-pipelined add/accumulate unit. Generalises the single-cycle acc
//   block to any WIDTH, with ripple carry split into SEG_W-bit pipeline stages.
//   Three per-transaction modes (ADD/ACC/LOAD) and a valid/ready handshake on each side.
//   Sits between the operand source and the result consumer in the arithmetic datapath.
// PARAMETERS
//   WIDTH  128  operand width; WIDTH % SEG_W == 0 is required (elaboration error otherwise)
//   SEG_W  32   bits summed per pipeline stage; NSEG = WIDTH/SEG_W stages (localparam)
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low reset
//   in_valid   in   1        transaction offered
//   in_ready   out  1        transaction accepted on edge when in_valid && in_ready
//   mode       in   2        00 ADD, 01 ACC, 10 LOAD, 11 reserved (treated as ADD)
//   data_cin   in   1        carry-in
//   data_in1   in   WIDTH    operand A
//   data_in2   in   WIDTH    operand B (ignored in ACC)
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result on edge when out_valid && out_ready
//   data_out   out  WIDTH+1  {carry_out, sum}
//   ovf        out  1        sticky accumulator overflow (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (reset==0, async): all stage valids, acc, data_out, ovf = 0; in_ready = 1 after release.
//     In-flight transactions are discarded; no partial result is ever presented.
//   - ADD:  data_out = A + B + cin; acc unchanged.
//   - LOAD: data_out = A + B + cin; acc <= sum[WIDTH-1:0].
//   - ACC:  data_out = acc + A + cin; acc <= sum[WIDTH-1:0]; carry_out wraps, not kept in acc.
//   - Stage k (0..NSEG-1) adds segment k plus carry from stage k-1. Upper operand segments
//     and mode travel with the transaction. Acc segment k is read/written in stage k, so
//     back-to-back ACC/LOAD transactions see the previous result with no bubble.
//   - Latency: accepted on edge t -> out_valid on edge t+NSEG (no stall). Throughput 1/cycle.
//   - Stall: stall = out_valid && !out_ready freezes every stage and the acc register.
//     in_ready = !stall (combinational from out_ready). Bubbles move forward when not stalled.
//   - Output: data_out/out_valid registered; data_out holds while stalled. It is don't-care
//     when out_valid==0 but keeps its last value.
//   - Boundaries:
//       - All-ones + cin ripples across every segment -> carry_out=1, sum=0.
//       - Accept and retire on the same edge is legal at full occupancy.
//       - in_valid with in_ready==0 has no effect; the source holds its data.
// CONFIGURATION
//   ACC_PIPE_OVF_EN defined:
//     - ovf sets on an ACC result with carry_out=1, registered with the output.
//     - ovf clears on a LOAD result; ADD leaves it unchanged. Reset clears it.
//   ACC_PIPE_OVF_EN undefined: no ovf logic; ovf tied to 0.
// TESTING (WIDTH=128, SEG_W=32, NSEG=4, out_ready=1 unless stated)
//   1 ADD A=32'hAAAAAAAA B=32'h55555555 cin=1 -> data_out=129'h1_0000_0000, out_valid 4 edges after accept
//   2 ADD A={128{1'b1}} B=0 cin=1 -> data_out={1'b1,128'h0} (full carry ripple)
//   3 LOAD A=5 B=0 cin=0, then ACC A=3 cin=0 x3 back-to-back -> 5,8,11,14 on consecutive cycles
//   4 out_ready=0 for 6 cycles while 6 ADDs offered -> in_ready drops after pipeline fills;
//     after release, all results in order with no loss or duplicates
//   5 reset pulled low with 3 in flight -> out_valid=0 immediately; next ACC A=1 yields 1 (acc=0)
//   6 [OVF_EN] LOAD A={128{1'b1}}, ACC A=1 -> data_out={1'b1,128'h0}, ovf=1; then LOAD A=0 -> ovf=0

Source files
------------

// File: rtl/acc_pipe.sv
// acc_pipe: segment-pipelined add/accumulate unit.
//   Sums are rippled SEG_W bits per stage across NSEG = WIDTH/SEG_W stages, behind
//   one input register, so a result appears NSEG edges after acceptance.
//   Modes: 00 ADD, 01 ACC (acc + A + cin), 10 LOAD (A + B + cin, loads acc), 11 = ADD.
//   Optional feature macro: ACC_PIPE_OVF_EN enables the sticky accumulator overflow
//   flag; when undefined, ovf is tied low.
module acc_pipe #(
  parameter int WIDTH = 128,
  parameter int SEG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             data_cin,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   data_out,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;

  if (WIDTH % SEG_W != 0) begin : g_bad_width
    $error("acc_pipe: WIDTH must be a multiple of SEG_W");
  end

  function automatic logic is_acc(input logic [1:0] m);
    return m == 2'b01;
  endfunction

  function automatic logic is_load(input logic [1:0] m);
    return m == 2'b10;
  endfunction

  // Replace segment idx of a word with a freshly computed partial sum.
  function automatic logic [WIDTH-1:0] put_seg(input logic [WIDTH-1:0] w, input int idx,
                                               input logic [SEG_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = w;
    r[idx*SEG_W +: SEG_W] = s;
    return r;
  endfunction

  // Stage register k feeds adder stage k. Index 0 is the input capture register.
  // x_q holds the finished sum segments below k and the untouched A segments from k up.
  logic             vld_q   [NSEG];
  logic [1:0]       mode_q  [NSEG];
  logic             carry_q [NSEG];
  logic [WIDTH-1:0] x_q     [NSEG];
  logic [WIDTH-1:0] b_q     [NSEG];

  logic [SEG_W:0]   seg_sum [NSEG];
  logic [WIDTH-1:0] x_d     [NSEG];
  logic [NSEG-1:0]  acc_we;

  logic [WIDTH-1:0] acc_q;
  logic             out_vld_q;
  logic [WIDTH:0]   dout_q;
  logic             stall;
  logic             adv;

  // A held result blocks the whole pipe, including the accumulator.
  assign stall    = out_vld_q && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W-1:0] opnd;
    // ACC replaces operand B with the live accumulator segment, which the previous
    // transaction wrote on the edge it left this stage.
    assign opnd       = is_acc(mode_q[k]) ? acc_q[k*SEG_W +: SEG_W] : b_q[k][k*SEG_W +: SEG_W];
    assign seg_sum[k] = {1'b0, x_q[k][k*SEG_W +: SEG_W]} + {1'b0, opnd}
                        + {{SEG_W{1'b0}}, carry_q[k]};
    assign x_d[k]     = put_seg(x_q[k], k, seg_sum[k][SEG_W-1:0]);
    assign acc_we[k]  = adv && vld_q[k] && (is_acc(mode_q[k]) || is_load(mode_q[k]));
  end

  // Only the top segment of the last B copy feeds an adder; the rest is dead.
  logic unused_b;
  assign unused_b = ^b_q[NSEG-1];

  // Valid bits advance with the data; reset drops every in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSEG; i++) vld_q[i] <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NSEG; i++) vld_q[i] <= vld_q[i-1];
      out_vld_q <= vld_q[NSEG-1];
    end
  end

  // Operand/partial-sum pipeline; only loaded when a valid transaction moves in.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        x_q[0]     <= data_in1;
        b_q[0]     <= data_in2;
        carry_q[0] <= data_cin;
        mode_q[0]  <= mode;
      end
      for (int i = 1; i < NSEG; i++) begin
        if (vld_q[i-1]) begin
          x_q[i]     <= x_d[i-1];
          b_q[i]     <= b_q[i-1];
          carry_q[i] <= seg_sum[i-1][SEG_W];
          mode_q[i]  <= mode_q[i-1];
        end
      end
    end
  end

  // Output register only changes when a real result arrives, so it holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else if (adv && vld_q[NSEG-1]) begin
      dout_q <= {seg_sum[NSEG-1][SEG_W], x_d[NSEG-1]};
    end
  end

  // Accumulator segment k is written by the transaction leaving stage k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (acc_we[k]) acc_q[k*SEG_W +: SEG_W] <= seg_sum[k][SEG_W-1:0];
      end
    end
  end

  assign out_valid = out_vld_q;
  assign data_out  = dout_q;

`ifdef ACC_PIPE_OVF_EN
  logic ovf_q;

  // Sticky overflow: set by an ACC carry-out, cleared by LOAD, updated with the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (adv && vld_q[NSEG-1]) begin
      if (is_acc(mode_q[NSEG-1]) && seg_sum[NSEG-1][SEG_W]) begin
        ovf_q <= 1'b1;
      end else if (is_load(mode_q[NSEG-1])) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
